// File: rtl/serial_subtractor8.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor8
// Purpose  : Bit-serial 8-bit subtractor (A-B, LSB first, one cell) with
//            registered result and active-low seven-segment decode.
// Options  : SUB_SIGNED_OVF_EN adds the registered signed-overflow output.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor8 (
  input  logic       clock,
  input  logic       Reset,
  input  logic [7:0] D,
  input  logic       load,
  output logic [7:0] Diff,
  output logic       Borrow,
  output logic       Busy,
  output logic       Done,
`ifdef SUB_SIGNED_OVF_EN
  output logic       Overflow,
`endif
  output logic [6:0] HEX1,
  output logic [6:0] HEX0
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT_B = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0] state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       bor_q, bor_d;
  logic [7:0] diff_q, diff_d;
  logic       borrow_q, borrow_d;
  logic       d_bit, b_out;

  assign d_bit = a_q[0] ^ b_q[0] ^ bor_q;
  assign b_out = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bor_q);

`ifdef SUB_SIGNED_OVF_EN
  // Operand sign bits are kept aside because A and B are shifted away in RUN.
  logic a7_q, a7_d, b7_q, b7_d, ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    bor_d    = bor_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SUB_SIGNED_OVF_EN
    a7_d  = a7_q;
    b7_d  = b7_q;
    ovf_d = ovf_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (load) begin
          a_d     = D;
          state_d = S_WAIT_B;
`ifdef SUB_SIGNED_OVF_EN
          a7_d = D[7];
`endif
        end
      end
      S_WAIT_B: begin
        if (load) begin
          b_d     = D;
          bor_d   = 1'b0;
          cnt_d   = 3'd0;
          state_d = S_RUN;
`ifdef SUB_SIGNED_OVF_EN
          b7_d = D[7];
`endif
        end
      end
      S_RUN: begin
        a_d   = {1'b0, a_q[7:1]};
        b_d   = {1'b0, b_q[7:1]};
        sr_d  = {d_bit, sr_q[7:1]};
        bor_d = b_out;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          diff_d   = {d_bit, sr_q[7:1]};
          borrow_d = b_out;
          state_d  = S_DONE;
`ifdef SUB_SIGNED_OVF_EN
          ovf_d = (a7_q != b7_q) && (d_bit != a7_q);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      a_q      <= 8'd0;
      b_q      <= 8'd0;
      sr_q     <= 8'd0;
      cnt_q    <= 3'd0;
      bor_q    <= 1'b0;
      diff_q   <= 8'd0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      bor_q    <= bor_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

`ifdef SUB_SIGNED_OVF_EN
  always_ff @(posedge clock) begin
    if (Reset) begin
      a7_q  <= 1'b0;
      b7_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      a7_q  <= a7_d;
      b7_q  <= b7_d;
      ovf_q <= ovf_d;
    end
  end
  assign Overflow = ovf_q;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign Diff   = diff_q;
  assign Borrow = borrow_q;
  assign Busy   = (state_q == S_RUN);
  assign Done   = (state_q == S_DONE);
  assign HEX1   = seg7(diff_q[7:4]);
  assign HEX0   = seg7(diff_q[3:0]);

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor8.sv
`default_nettype none
// Directed self-checking bench for serial_subtractor8.
module tb_serial_subtractor8;
  logic       clock = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] D = 8'd0;
  logic       load = 1'b0;
  logic [7:0] Diff;
  logic       Borrow, Busy, Done;
  logic [6:0] HEX1, HEX0;
`ifdef SUB_SIGNED_OVF_EN
  logic       Overflow;
`endif

  int checks = 0;
  int passed = 0;

  serial_subtractor8 dut (
    .clock(clock), .Reset(Reset), .D(D), .load(load),
    .Diff(Diff), .Borrow(Borrow), .Busy(Busy), .Done(Done),
`ifdef SUB_SIGNED_OVF_EN
    .Overflow(Overflow),
`endif
    .HEX1(HEX1), .HEX0(HEX0)
  );

  always #5 clock = ~clock;

  task automatic do_load(input logic [7:0] v);
    @(negedge clock);
    D = v;
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
  endtask

  // Observes the RUN phase; optionally pulses load mid-run. Bounded at 20 cycles.
  task automatic run_cycles(input bit pulse, output int busy_cnt, output bit partial,
                            output bit both_high);
    logic [7:0] prev;
    prev = Diff;
    busy_cnt = 0;
    partial = 0;
    both_high = 0;
    for (int k = 0; k < 20; k++) begin
      if (!Busy) break;
      busy_cnt++;
      if (Diff !== prev) partial = 1;
      if (Done) both_high = 1;
      load = (pulse && k == 3);
      D = 8'hFF;
      @(negedge clock);
    end
    load = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({Diff, Borrow, Busy, Done} !== 11'd0)
      $display("FAIL reset_outputs: got Diff=%h Borrow=%b Busy=%b Done=%b, want 0", Diff, Borrow, Busy, Done);
    else passed++;
    checks++;
    if (HEX1 !== 7'b1000000 || HEX0 !== 7'b1000000)
      $display("FAIL reset_hex: got %b %b, want 1000000 1000000", HEX1, HEX0);
    else passed++;
    Reset = 1'b0;
  endtask

  task automatic test_basic;
    int n; bit p, bh;
    do_load(8'h50);
    do_load(8'h20);
    run_cycles(0, n, p, bh);
    checks++;
    if (n !== 8 || p || bh) $display("FAIL basic_timing: busy=%0d partial=%b both=%b, want 8 0 0", n, p, bh);
    else passed++;
    checks++;
    if (Diff !== 8'h30 || Borrow !== 1'b0 || Done !== 1'b1 || Busy !== 1'b0)
      $display("FAIL basic_result: got %h/%b done=%b busy=%b, want 30/0 1 0", Diff, Borrow, Done, Busy);
    else passed++;
    checks++;
    if (HEX1 !== 7'b0110000 || HEX0 !== 7'b1000000)
      $display("FAIL basic_hex: got %b %b, want 0110000 1000000", HEX1, HEX0);
    else passed++;
  endtask

  task automatic test_borrow;
    int n; bit p, bh;
    do_load(8'h10);
    checks++;
    if (Done !== 1'b0 || Diff !== 8'h30)
      $display("FAIL reload_hold: got done=%b Diff=%h, want 0 30", Done, Diff);
    else passed++;
    do_load(8'h20);
    run_cycles(0, n, p, bh);
    checks++;
    if (n !== 8 || p || Diff !== 8'hF0 || Borrow !== 1'b1)
      $display("FAIL borrow_result: busy=%0d partial=%b got %h/%b, want 8 0 F0/1", n, p, Diff, Borrow);
    else passed++;
    checks++;
    if (HEX1 !== 7'b0001110 || HEX0 !== 7'b1000000)
      $display("FAIL borrow_hex: got %b %b, want 0001110 1000000", HEX1, HEX0);
    else passed++;
  endtask

  task automatic test_midrun_load;
    int n; bit p, bh;
    do_load(8'h33);
    do_load(8'h33);
    run_cycles(1, n, p, bh);
    checks++;
    if (n !== 8 || p || Done !== 1'b1 || Diff !== 8'h00 || Borrow !== 1'b0)
      $display("FAIL midrun_load: busy=%0d partial=%b done=%b got %h/%b, want 8 0 1 00/0", n, p, Done, Diff, Borrow);
    else passed++;
  endtask

  task automatic test_edges;
    int n; bit p, bh;
    do_load(8'h00);
    do_load(8'hFF);
    run_cycles(0, n, p, bh);
    checks++;
    if (Diff !== 8'h01 || Borrow !== 1'b1 || HEX0 !== 7'b1111001)
      $display("FAIL zero_minus_ff: got %h/%b hex0=%b, want 01/1 1111001", Diff, Borrow, HEX0);
    else passed++;
    do_load(8'hFF);
    do_load(8'h00);
    run_cycles(0, n, p, bh);
    checks++;
    if (Diff !== 8'hFF || Borrow !== 1'b0 || HEX1 !== 7'b0001110 || HEX0 !== 7'b0001110)
      $display("FAIL ff_minus_zero: got %h/%b hex=%b %b, want FF/0", Diff, Borrow, HEX1, HEX0);
    else passed++;
    do_load(8'hA7);
    do_load(8'h5C);
    run_cycles(0, n, p, bh);
    checks++;
    if (Diff !== 8'h4B || Borrow !== 1'b0 || HEX1 !== 7'b0011001 || HEX0 !== 7'b0000011)
      $display("FAIL a7_minus_5c: got %h/%b hex=%b %b, want 4B/0 0011001 0000011", Diff, Borrow, HEX1, HEX0);
    else passed++;
  endtask

  task automatic test_reset_abort;
    int n; bit p, bh;
    do_load(8'h50);
    do_load(8'h20);
    run_cycles(0, n, p, bh);
    do_load(8'h09);
    do_load(8'h04);
    repeat (3) @(negedge clock);
    checks++;
    if (Busy !== 1'b1 || Diff !== 8'h30)
      $display("FAIL abort_prerun: got busy=%b Diff=%h, want 1 30", Busy, Diff);
    else passed++;
    Reset = 1'b1;
    @(negedge clock);
    Reset = 1'b0;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Diff !== 8'h00 || Borrow !== 1'b0 || HEX1 !== 7'b1000000)
      $display("FAIL abort_reset: got busy=%b done=%b Diff=%h borrow=%b, want 0 0 00 0", Busy, Done, Diff, Borrow);
    else passed++;
    repeat (10) @(negedge clock);
    checks++;
    if (Done !== 1'b0 || Diff !== 8'h00)
      $display("FAIL abort_stays_idle: got done=%b Diff=%h, want 0 00", Done, Diff);
    else passed++;
  endtask

  task automatic test_reset_priority;
    int n; bit p, bh;
    @(negedge clock);
    Reset = 1'b1;
    load = 1'b1;
    D = 8'hEE;
    @(negedge clock);
    Reset = 1'b0;
    load = 1'b0;
    do_load(8'h05);
    do_load(8'h03);
    run_cycles(0, n, p, bh);
    checks++;
    if (n !== 8 || Diff !== 8'h02 || Borrow !== 1'b0)
      $display("FAIL reset_priority: busy=%0d got %h/%b, want 8 02/0", n, Diff, Borrow);
    else passed++;
  endtask

`ifdef SUB_SIGNED_OVF_EN
  task automatic test_overflow;
    int n; bit p, bh;
    do_load(8'h80);
    do_load(8'h01);
    run_cycles(0, n, p, bh);
    checks++;
    if (Diff !== 8'h7F || Overflow !== 1'b1 || Borrow !== 1'b0)
      $display("FAIL ovf_set: got %h ovf=%b borrow=%b, want 7F 1 0", Diff, Overflow, Borrow);
    else passed++;
    do_load(8'h05);
    do_load(8'h03);
    run_cycles(0, n, p, bh);
    checks++;
    if (Diff !== 8'h02 || Overflow !== 1'b0)
      $display("FAIL ovf_clear: got %h ovf=%b, want 02 0", Diff, Overflow);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_midrun_load();
    test_edges();
    test_reset_abort();
    test_reset_priority();
`ifdef SUB_SIGNED_OVF_EN
    test_overflow();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
`default_nettype wire
